// File: rtl/cfg_pkg.sv
// Shared definitions for the serial configuration front end and the register bank it feeds.
package cfg_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SHIFT  = SHIFT,
    ST_PARITY = PARITY
  } cfg_state_e;

  localparam int CFG_FRAME_PAYLOAD_W = 4;

  // Register bank address map
  localparam logic [1:0] CH0    = 2'd0;
  localparam logic [1:0] CH1    = 2'd1;
  localparam logic [1:0] CH2    = 2'd2;
  localparam logic [1:0] CRC_EN = 2'd3;

  function automatic logic even_parity_ok(input logic [CFG_FRAME_PAYLOAD_W-1:0] payload,
                                          input logic par);
    return ~(^payload ^ par);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {W{1'b1}})) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/config_serial_if.sv
// Deserialises framed 1-bit config stream into register-bank writes, with optional
// even-parity check, abort detection and a saturating error counter.
module config_serial_if
  import cfg_pkg::*;
#(
  parameter bit PARITY_EN = 1'b1,
  parameter int ERR_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  input  logic                 cfg_sdi,
  output logic [1:0]           config_addr,
  output logic [1:0]           config_data,
  output logic                 config_en,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

  localparam logic [1:0] LAST_BIT = 2'(CFG_FRAME_PAYLOAD_W - 1);

  cfg_state_e                     state_q;
  logic [1:0]                     cnt_q;
  logic [CFG_FRAME_PAYLOAD_W-1:0] shreg_q;
  logic [CFG_FRAME_PAYLOAD_W-1:0] shreg_d;
  logic [1:0]                     addr_q;
  logic [1:0]                     data_q;
  logic                           en_q;
  logic                           err_q;

  assign shreg_d = {shreg_q[CFG_FRAME_PAYLOAD_W-2:0], cfg_sdi};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      en_q  <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_valid && cfg_sdi) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
          end
        end
        ST_SHIFT: begin
          // Any gap in cfg_valid kills the frame; partial bits are simply abandoned.
          if (!cfg_valid) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b1;
          end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_q + 2'd1;
            if (cnt_q == LAST_BIT) begin
              if (PARITY_EN) begin
                state_q <= ST_PARITY;
              end else begin
                state_q <= ST_IDLE;
                addr_q  <= shreg_d[3:2];
                data_q  <= shreg_d[1:0];
                en_q    <= 1'b1;
              end
            end
          end
        end
        ST_PARITY: begin
          state_q <= ST_IDLE;
          if (cfg_valid && even_parity_ok(shreg_q, cfg_sdi)) begin
            addr_q <= shreg_q[3:2];
            data_q <= shreg_q[1:0];
            en_q   <= 1'b1;
          end else begin
            err_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_i  (err_q),
    .count_o(err_cnt)
  );

  assign config_addr = addr_q;
  assign config_data = data_q;
  assign config_en   = en_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_config_serial_if.sv
// Randomised bench: a frame-level parser model predicts per-cycle outputs of both builds.
module tb_config_serial_if;
  import cfg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, cfg_valid, cfg_sdi;

  logic [1:0] addr1, data1, addr0, data0;
  logic       en1, err1, busy1, en0, err0, busy0;
  logic [3:0] cnt1, cnt0;

  config_serial_if #(.PARITY_EN(1'b1), .ERR_CNT_W(4)) u_pe1 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_sdi(cfg_sdi),
    .config_addr(addr1), .config_data(data1), .config_en(en1),
    .frame_err(err1), .err_cnt(cnt1), .busy(busy1)
  );

  config_serial_if #(.PARITY_EN(1'b0), .ERR_CNT_W(4)) u_pe0 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_sdi(cfg_sdi),
    .config_addr(addr0), .config_data(data0), .config_en(en0),
    .frame_err(err0), .err_cnt(cnt0), .busy(busy0)
  );

  logic       sel_pe;
  logic [1:0] o_addr, o_data;
  logic       o_en, o_err, o_busy;
  logic [3:0] o_cnt;
  assign o_addr = sel_pe ? addr1 : addr0;
  assign o_data = sel_pe ? data1 : data0;
  assign o_en   = sel_pe ? en1   : en0;
  assign o_err  = sel_pe ? err1  : err0;
  assign o_busy = sel_pe ? busy1 : busy0;
  assign o_cnt  = sel_pe ? cnt1  : cnt0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  bit sv[$];
  bit sd[$];

  task automatic push_bit(input bit v, input bit d);
    sv.push_back(v);
    sd.push_back(d);
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_bit(1'($urandom_range(0, 1)), 1'b0);
  endtask

  // abort_at: index within the frame (1..L) where cfg_valid drops, -1 for none
  task automatic push_frame(input int pe, input logic [1:0] a, input logic [1:0] d,
                            input bit bad_par, input int abort_at);
    bit fb[6];
    int len;
    fb[0] = 1'b1;
    fb[1] = a[1];
    fb[2] = a[0];
    fb[3] = d[1];
    fb[4] = d[0];
    fb[5] = a[1] ^ a[0] ^ d[1] ^ d[0] ^ bad_par;
    len = (pe != 0) ? 6 : 5;
    for (int j = 0; j < len; j++) begin
      if (j == abort_at) begin
        push_bit(1'b0, 1'($urandom_range(0, 1)));
        break;
      end
      push_bit(1'b1, fb[j]);
    end
  endtask

  task automatic rand_frames(input int pe, input int count);
    int l;
    l = (pe != 0) ? 5 : 4;
    for (int i = 0; i < count; i++) begin
      push_frame(pe, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, l)) : -1);
      push_idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr"}, 32'(o_addr), 0);
    chk({tag, "_data"}, 32'(o_data), 0);
    chk({tag, "_en"},   32'(o_en),   0);
    chk({tag, "_err"},  32'(o_err),  0);
    chk({tag, "_cnt"},  32'(o_cnt),  0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
  endtask

  // Parse the queued stream frame by frame, then drive it cycle by cycle from reset.
  task automatic run_stream(input int pe, input string name);
    int n, l, t, k, last, par, cnt;
    logic [1:0] cur_a, cur_d;
    bit e_en[], e_err[], e_busy[];
    logic [1:0] e_addr[], e_data[], c_addr[], c_data[];
    int e_cnt[];
    n = sv.size();
    l = (pe != 0) ? 5 : 4;
    e_en = new[n]; e_err = new[n]; e_busy = new[n];
    e_addr = new[n]; e_data = new[n]; c_addr = new[n]; c_data = new[n]; e_cnt = new[n];
    for (int i = 0; i < n; i++) begin
      e_en[i] = 0; e_err[i] = 0; e_busy[i] = 0;
    end
    t = 0;
    while (t < n) begin
      if (sv[t] && sd[t]) begin
        k = 1;
        while (k <= l && t + k < n && sv[t+k]) k++;
        last = (k > l) ? t + l : t + k;
        for (int i = t; i < last && i < n; i++) e_busy[i] = 1;
        if (k <= l && t + k >= n) begin
          t = n;
        end else if (k <= l) begin
          e_err[t+k] = 1;
          t = t + k + 1;
        end else begin
          par = 0;
          for (int i = 1; i <= l; i++) par = par + int'(sd[t+i]);
          if (pe != 0 && (par % 2) != 0) begin
            e_err[t+l] = 1;
          end else begin
            e_en[t+l]   = 1;
            c_addr[t+l] = {sd[t+1], sd[t+2]};
            c_data[t+l] = {sd[t+3], sd[t+4]};
          end
          t = t + l + 1;
        end
      end else begin
        t++;
      end
    end
    cur_a = 0; cur_d = 0; cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (e_en[i]) begin
        cur_a = c_addr[i];
        cur_d = c_data[i];
      end
      e_addr[i] = cur_a;
      e_data[i] = cur_d;
      e_cnt[i]  = (cnt > 15) ? 15 : cnt;
      if (e_err[i]) cnt++;
    end

    sel_pe    = (pe != 0);
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_sdi   = 1'b0;
    #1;
    check_zero({name, "_rst"});
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < n; i++) begin
      cfg_valid = sv[i];
      cfg_sdi   = sd[i];
      @(posedge clk);
      #1;
      chk($sformatf("%s_en@%0d", name, i),   32'(o_en),   32'(e_en[i]));
      chk($sformatf("%s_err@%0d", name, i),  32'(o_err),  32'(e_err[i]));
      chk($sformatf("%s_busy@%0d", name, i), 32'(o_busy), 32'(e_busy[i]));
      chk($sformatf("%s_addr@%0d", name, i), 32'(o_addr), 32'(e_addr[i]));
      chk($sformatf("%s_data@%0d", name, i), 32'(o_data), 32'(e_data[i]));
      chk($sformatf("%s_cnt@%0d", name, i),  32'(o_cnt),  32'(e_cnt[i]));
      if (e_en[i])
        $display("%s t=%0d write addr=%0d data=%0d", name, i, e_addr[i], e_data[i]);
      if (e_err[i])
        $display("%s t=%0d frame_err count_before=%0d", name, i, e_cnt[i]);
    end
    sv.delete();
    sd.delete();
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_sdi = 1'b0; sel_pe = 1'b1;

    // Directed parity build: good write, parity error, abort, back-to-back
    push_bit(1, 0); push_bit(1, 0); push_bit(1, 0); push_bit(0, 0); push_bit(0, 1);
    push_frame(1, CH2, 2'd2, 1'b0, -1);
    push_idle(2);
    push_frame(1, CRC_EN, 2'd1, 1'b1, -1);
    push_idle(2);
    push_frame(1, CH0, 2'd0, 1'b0, 2);
    push_idle(2);
    push_frame(1, CRC_EN, 2'd1, 1'b0, -1);
    push_frame(1, CH0, 2'd3, 1'b0, -1);
    push_idle(3);
    run_stream(1, "pe1_dir");

    rand_frames(1, 40);
    push_idle(3);
    run_stream(1, "pe1_rnd");

    // Saturation: 20 parity-error frames
    for (int i = 0; i < 20; i++) begin
      push_frame(1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1, -1);
      push_idle(int'($urandom_range(0, 1)));
    end
    push_idle(3);
    run_stream(1, "pe1_sat");
    chk("pe1_sat_final", 32'(o_cnt), 15);

    // No-parity build, ending mid-frame so reset lands inside a frame
    push_idle(2);
    push_frame(0, CH2, 2'd1, 1'b0, -1);
    push_idle(2);
    rand_frames(0, 10);
    push_bit(1, 1); push_bit(1, 0); push_bit(1, 1);
    run_stream(0, "pe0_a");
    chk("pe0_midframe_busy", 32'(o_busy), 1);
    rst_n = 1'b0;
    #1;
    check_zero("pe0_midrst");
    @(posedge clk);
    #1;
    chk("pe0_midrst_hold_en", 32'(o_en), 0);

    push_frame(0, CH1, 2'd3, 1'b0, -1);
    rand_frames(0, 10);
    push_idle(3);
    run_stream(0, "pe0_b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
